irq_seq: RTL and testbench

- Interrupt/BRK entry sequencer for the 6502 core; the consumer of the processor status register.
- At an instruction boundary it takes a pending NMI, BRK or IRQ and pushes PCH, PCL and the status byte to the stack page.
- It then fetches the 16-bit vector and hands the new PC and an I-flag set request back to the core.

---
 rtl/irq_seq.sv | 217 +++++++++++++++++++++
 tb/tb_irq_seq.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_seq.sv
`default_nettype none
// ============================================================================
//  Module   : irq_seq
//  Purpose  : 6502 interrupt / BRK entry sequencer. At an instruction boundary
//             it takes a pending NMI, a BRK or an unmasked IRQ. It pushes PCH,
//             PCL and P to the stack page, then fetches the 16-bit vector and
//             hands the new PC plus an I-flag set request back to the core.
//  Options  : IRQ_SEQ_NMI_HIJACK_EN - when defined, an NMI edge seen during the
//             push phase of an IRQ/BRK sequence redirects its vector fetch to
//             the NMI vector and consumes the NMI.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_seq #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        instr_boundary,
  input  logic        brk_req,
  input  logic        irq_l,
  input  logic        nmi_l,
  input  logic [7:0]  status,
  input  logic [15:0] pc,
  input  logic [7:0]  sp,
  input  logic [7:0]  data_in,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        set_int_disable,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_PCH = 3'd1,
    PUSH_PCL = 3'd2,
    PUSH_P   = 3'd3,
    VEC_LO   = 3'd4,
    VEC_HI   = 3'd5,
    LOAD     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    KIND_NMI = 2'd0,
    KIND_BRK = 2'd1,
    KIND_IRQ = 2'd2
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [15:0] pc_l_q, pc_l_d;
  logic [7:0]  sp_l_q, sp_l_d;
  logic [7:0]  status_l_q, status_l_d;
  logic        use_nmi_vec_q, use_nmi_vec_d;
  logic        nmi_prev_q, nmi_prev_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic [15:0] pc_new_q, pc_new_d;

  logic        nmi_edge;
  logic        irq_take;
  logic        start;
  logic        in_push;
  logic        hijack;
  logic [15:0] vec;
  logic [7:0]  sp_m1;
  logic [7:0]  sp_m2;
  logic [7:0]  push_p;

  assign nmi_edge = nmi_prev_q & ~nmi_l;
  assign irq_take = ~irq_l & ~status[2];
  assign start    = (state_q == IDLE) && instr_boundary &&
                    (nmi_pending_q || brk_req || irq_take);
  assign in_push  = (state_q == PUSH_PCH) || (state_q == PUSH_PCL) ||
                    (state_q == PUSH_P);
  assign vec      = use_nmi_vec_q ? NMI_VEC : IRQ_VEC;
  assign sp_m1    = sp_l_q - 8'd1;
  assign sp_m2    = sp_l_q - 8'd2;
  // Bit 5 always reads back as 1; B (bit 4) marks a software BRK entry.
  assign push_p   = (status_l_q & 8'hCF) | 8'h20 |
                    ((kind_q == KIND_BRK) ? 8'h10 : 8'h00);
  assign pc_new   = pc_new_q;

`ifdef IRQ_SEQ_NMI_HIJACK_EN
  assign hijack = nmi_edge && in_push && (kind_q != KIND_NMI);
`else
  assign hijack = 1'b0;
`endif

  // NMI falling-edge latch; a fresh edge overrides a clear from acceptance.
  always_comb begin
    nmi_prev_d    = nmi_l;
    nmi_pending_d = nmi_pending_q;
    if (start || hijack) begin
      nmi_pending_d = 1'b0;
    end
    if (nmi_edge && !hijack) begin
      nmi_pending_d = 1'b1;
    end
  end

  // Sequencer next state and bus outputs, one bus operation per state.
  always_comb begin
    state_d         = state_q;
    kind_d          = kind_q;
    pc_l_d          = pc_l_q;
    sp_l_d          = sp_l_q;
    status_l_d      = status_l_q;
    use_nmi_vec_d   = use_nmi_vec_q;
    pc_new_d        = pc_new_q;
    addr            = 16'h0000;
    data_out        = 8'h00;
    wr_en           = 1'b0;
    rd_en           = 1'b0;
    sp_dec          = 1'b0;
    pc_load         = 1'b0;
    set_int_disable = 1'b0;
    busy            = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = PUSH_PCH;
          pc_l_d        = pc;
          sp_l_d        = sp;
          status_l_d    = status;
          use_nmi_vec_d = nmi_pending_q;
          if (nmi_pending_q) begin
            kind_d = KIND_NMI;
          end else if (brk_req) begin
            kind_d = KIND_BRK;
          end else begin
            kind_d = KIND_IRQ;
          end
        end
      end
      PUSH_PCH: begin
        addr     = {STACK_PAGE, sp_l_q};
        data_out = pc_l_q[15:8];
        wr_en    = 1'b1;
        sp_dec   = 1'b1;
        state_d  = PUSH_PCL;
      end
      PUSH_PCL: begin
        addr     = {STACK_PAGE, sp_m1};
        data_out = pc_l_q[7:0];
        wr_en    = 1'b1;
        sp_dec   = 1'b1;
        state_d  = PUSH_P;
      end
      PUSH_P: begin
        addr     = {STACK_PAGE, sp_m2};
        data_out = push_p;
        wr_en    = 1'b1;
        sp_dec   = 1'b1;
        state_d  = VEC_LO;
      end
      VEC_LO: begin
        addr           = vec;
        rd_en          = 1'b1;
        pc_new_d[7:0]  = data_in;
        state_d        = VEC_HI;
      end
      VEC_HI: begin
        addr           = vec + 16'd1;
        rd_en          = 1'b1;
        pc_new_d[15:8] = data_in;
        state_d        = LOAD;
      end
      LOAD: begin
        pc_load         = 1'b1;
        set_int_disable = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Only raised during the push phase, so the vector fetch sees it.
    if (hijack) begin
      use_nmi_vec_d = 1'b1;
    end
  end

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q       <= IDLE;
      kind_q        <= KIND_NMI;
      pc_l_q        <= 16'h0000;
      sp_l_q        <= 8'h00;
      status_l_q    <= 8'h00;
      use_nmi_vec_q <= 1'b0;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
      pc_new_q      <= 16'h0000;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      pc_l_q        <= pc_l_d;
      sp_l_q        <= sp_l_d;
      status_l_q    <= status_l_d;
      use_nmi_vec_q <= use_nmi_vec_d;
      nmi_prev_q    <= nmi_prev_d;
      nmi_pending_q <= nmi_pending_d;
      pc_new_q      <= pc_new_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_seq
//  Purpose  : Directed self-checking bench for irq_seq. A small vector ROM
//             answers reads; a monitor logs every active cycle so each
//             scenario can compare the bus trace against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_seq;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        instr_boundary;
  logic        brk_req;
  logic        irq_l;
  logic        nmi_l;
  logic [7:0]  status;
  logic [15:0] pc;
  logic [7:0]  sp;
  logic [7:0]  data_in;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        wr_en;
  logic        rd_en;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_new;
  logic        set_int_disable;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Flag order: {busy, wr_en, rd_en, sp_dec, pc_load, set_int_disable}
  localparam logic [5:0] FW = 6'b110100;
  localparam logic [5:0] FR = 6'b101000;
  localparam logic [5:0] FL = 6'b100011;

  typedef struct {
    logic [29:0] snap;
    logic [15:0] pcn;
    int          cyc;
  } ent_t;

  ent_t log_q[$];
  ent_t mon_e;

  irq_seq dut (
    .clk             (clk),
    .reset_l         (reset_l),
    .instr_boundary  (instr_boundary),
    .brk_req         (brk_req),
    .irq_l           (irq_l),
    .nmi_l           (nmi_l),
    .status          (status),
    .pc              (pc),
    .sp              (sp),
    .data_in         (data_in),
    .addr            (addr),
    .data_out        (data_out),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .sp_dec          (sp_dec),
    .pc_load         (pc_load),
    .pc_new          (pc_new),
    .set_int_disable (set_int_disable),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Vector ROM: NMI -> 5678, IRQ/BRK -> 1234.
  always_comb begin
    data_in = 8'h00;
    if (rd_en) begin
      case (addr)
        16'hFFFA: data_in = 8'h78;
        16'hFFFB: data_in = 8'h56;
        16'hFFFE: data_in = 8'h34;
        16'hFFFF: data_in = 8'h12;
        default:  data_in = 8'hEE;
      endcase
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Log every cycle in which the sequencer shows any activity.
  always @(negedge clk) begin
    if (busy || wr_en || rd_en || sp_dec || pc_load || set_int_disable ||
        (addr != 16'h0000) || (data_out != 8'h00)) begin
      mon_e.snap = {busy, wr_en, rd_en, sp_dec, pc_load, set_int_disable, addr, data_out};
      mon_e.pcn  = pc_new;
      mon_e.cyc  = cyc;
      log_q.push_back(mon_e);
    end
  end

  function automatic logic [29:0] pk(input logic [5:0] f, input logic [15:0] a, input logic [7:0] d);
    return {f, a, d};
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    wait_neg(3);
    n_vec++;
    if ({busy, wr_en, rd_en, sp_dec, pc_load, set_int_disable} !== 6'b0) begin
      n_miss++;
      $display("FAIL rst_strobes got %b want 000000",
               {busy, wr_en, rd_en, sp_dec, pc_load, set_int_disable});
    end
    n_vec++;
    if (addr !== 16'h0000) begin
      n_miss++; $display("FAIL rst_addr got %h want 0000", addr);
    end
    n_vec++;
    if (data_out !== 8'h00) begin
      n_miss++; $display("FAIL rst_data got %h want 00", data_out);
    end
    n_vec++;
    if (pc_new !== 16'h0000) begin
      n_miss++; $display("FAIL rst_pc_new got %h want 0000", pc_new);
    end
    reset_l = 1'b1;
    wait_neg(2);
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++; $display("FAIL rst_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_irq();
    logic [29:0] e[6];
    int t0;
    @(negedge clk);
    log_q.delete(); t0 = cyc;
    status = 8'h00; pc = 16'hC123; sp = 8'hFD; irq_l = 1'b0; instr_boundary = 1'b1;
    @(negedge clk);
    instr_boundary = 1'b0; irq_l = 1'b1; pc = 16'h0000; sp = 8'h00; status = 8'hFF;
    wait_neg(8);
    e[0] = pk(FW, 16'h01FD, 8'hC1); e[1] = pk(FW, 16'h01FC, 8'h23);
    e[2] = pk(FW, 16'h01FB, 8'h20); e[3] = pk(FR, 16'hFFFE, 8'h00);
    e[4] = pk(FR, 16'hFFFF, 8'h00); e[5] = pk(FL, 16'h0000, 8'h00);
    n_vec++;
    if (log_q.size() !== 6) begin
      n_miss++; $display("FAIL irq_len got %0d want 6", log_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        n_vec++;
        if (log_q[i].snap !== e[i]) begin
          n_miss++; $display("FAIL irq_cyc%0d got %h want %h", i, log_q[i].snap, e[i]);
        end
      end
    end
    if (log_q.size() >= 6) begin
      n_vec++;
      if (log_q[5].pcn !== 16'h1234) begin
        n_miss++; $display("FAIL irq_pc_new got %h want 1234", log_q[5].pcn);
      end
      n_vec++;
      if (log_q[5].cyc !== t0 + 6) begin
        n_miss++; $display("FAIL irq_latency got %0d want %0d", log_q[5].cyc - t0, 6);
      end
    end
  endtask

  task automatic test_masked_irq();
    @(negedge clk);
    log_q.delete();
    status = 8'h04; irq_l = 1'b0; instr_boundary = 1'b1;
    wait_neg(3);
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++; $display("FAIL masked_busy got %b want 0", busy);
    end
    status = 8'h00; irq_l = 1'b1;
    wait_neg(3);
    instr_boundary = 1'b0;
    wait_neg(1);
    n_vec++;
    if (log_q.size() !== 0) begin
      n_miss++; $display("FAIL masked_activity got %0d entries want 0", log_q.size());
    end
  endtask

  task automatic test_brk_nmi();
    logic [29:0] e[6];
    int t0;
    @(negedge clk);
    log_q.delete(); t0 = cyc;
    nmi_l = 1'b0; status = 8'hC3; pc = 16'h8000; sp = 8'hFF;
    @(negedge clk);
    brk_req = 1'b1; instr_boundary = 1'b1;
    @(negedge clk);
    brk_req = 1'b0; instr_boundary = 1'b0;
    wait_neg(8);
    e[0] = pk(FW, 16'h01FF, 8'h80); e[1] = pk(FW, 16'h01FE, 8'h00);
    e[2] = pk(FW, 16'h01FD, 8'hE3); e[3] = pk(FR, 16'hFFFA, 8'h00);
    e[4] = pk(FR, 16'hFFFB, 8'h00); e[5] = pk(FL, 16'h0000, 8'h00);
    n_vec++;
    if (log_q.size() !== 6) begin
      n_miss++; $display("FAIL nmi_len got %0d want 6", log_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        n_vec++;
        if (log_q[i].snap !== e[i]) begin
          n_miss++; $display("FAIL nmi_cyc%0d got %h want %h", i, log_q[i].snap, e[i]);
        end
      end
    end
    if (log_q.size() >= 6) begin
      n_vec++;
      if (log_q[5].pcn !== 16'h5678) begin
        n_miss++; $display("FAIL nmi_pc_new got %h want 5678", log_q[5].pcn);
      end
      n_vec++;
      if (log_q[0].cyc !== t0 + 2) begin
        n_miss++; $display("FAIL nmi_start got %0d want %0d", log_q[0].cyc - t0, 2);
      end
    end
    // The NMI was consumed, so this boundary must run as a BRK.
    log_q.delete();
    nmi_l = 1'b1; pc = 16'h8002; sp = 8'hFC; brk_req = 1'b1; instr_boundary = 1'b1;
    @(negedge clk);
    brk_req = 1'b0; instr_boundary = 1'b0;
    wait_neg(8);
    e[0] = pk(FW, 16'h01FC, 8'h80); e[1] = pk(FW, 16'h01FB, 8'h02);
    e[2] = pk(FW, 16'h01FA, 8'hF3); e[3] = pk(FR, 16'hFFFE, 8'h00);
    e[4] = pk(FR, 16'hFFFF, 8'h00); e[5] = pk(FL, 16'h0000, 8'h00);
    n_vec++;
    if (log_q.size() !== 6) begin
      n_miss++; $display("FAIL brk_len got %0d want 6", log_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        n_vec++;
        if (log_q[i].snap !== e[i]) begin
          n_miss++; $display("FAIL brk_cyc%0d got %h want %h", i, log_q[i].snap, e[i]);
        end
      end
    end
    if (log_q.size() >= 6) begin
      n_vec++;
      if (log_q[5].pcn !== 16'h1234) begin
        n_miss++; $display("FAIL brk_pc_new got %h want 1234", log_q[5].pcn);
      end
    end
  endtask

  task automatic test_sp_wrap();
    logic [29:0] e[6];
    @(negedge clk);
    log_q.delete();
    status = 8'h01; pc = 16'hABCD; sp = 8'h01; irq_l = 1'b0; instr_boundary = 1'b1;
    @(negedge clk);
    instr_boundary = 1'b0; irq_l = 1'b1;
    wait_neg(8);
    e[0] = pk(FW, 16'h0101, 8'hAB); e[1] = pk(FW, 16'h0100, 8'hCD);
    e[2] = pk(FW, 16'h01FF, 8'h21); e[3] = pk(FR, 16'hFFFE, 8'h00);
    e[4] = pk(FR, 16'hFFFF, 8'h00); e[5] = pk(FL, 16'h0000, 8'h00);
    n_vec++;
    if (log_q.size() !== 6) begin
      n_miss++; $display("FAIL wrap_len got %0d want 6", log_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        n_vec++;
        if (log_q[i].snap !== e[i]) begin
          n_miss++; $display("FAIL wrap_cyc%0d got %h want %h", i, log_q[i].snap, e[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] e[6];
    int t0;
    @(negedge clk);
    log_q.delete(); t0 = cyc;
    status = 8'h00; pc = 16'h2000; sp = 8'hF0; irq_l = 1'b0; instr_boundary = 1'b1;
    wait_neg(8);
    instr_boundary = 1'b0; irq_l = 1'b1;
    wait_neg(8);
    e[0] = pk(FW, 16'h01F0, 8'h20); e[1] = pk(FW, 16'h01EF, 8'h00);
    e[2] = pk(FW, 16'h01EE, 8'h20); e[3] = pk(FR, 16'hFFFE, 8'h00);
    e[4] = pk(FR, 16'hFFFF, 8'h00); e[5] = pk(FL, 16'h0000, 8'h00);
    n_vec++;
    if (log_q.size() !== 12) begin
      n_miss++; $display("FAIL b2b_len got %0d want 12", log_q.size());
    end
    for (int i = 0; i < 12; i++) begin
      if (i < log_q.size()) begin
        n_vec++;
        if (log_q[i].snap !== e[i % 6]) begin
          n_miss++; $display("FAIL b2b_cyc%0d got %h want %h", i, log_q[i].snap, e[i % 6]);
        end
      end
    end
    if (log_q.size() >= 12) begin
      n_vec++;
      if (log_q[6].cyc !== t0 + 8) begin
        n_miss++; $display("FAIL b2b_restart got %0d want %0d", log_q[6].cyc - t0, 8);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    log_q.delete();
    status = 8'h00; pc = 16'h1111; sp = 8'h80; irq_l = 1'b0; instr_boundary = 1'b1;
    @(negedge clk);
    instr_boundary = 1'b0; irq_l = 1'b1;
    @(negedge clk);
    reset_l = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++; $display("FAIL rstmid_busy got %b want 0", busy);
    end
    n_vec++;
    if (wr_en !== 1'b0) begin
      n_miss++; $display("FAIL rstmid_wr_en got %b want 0", wr_en);
    end
    n_vec++;
    if (pc_new !== 16'h0000) begin
      n_miss++; $display("FAIL rstmid_pc_new got %h want 0000", pc_new);
    end
    reset_l = 1'b1;
    wait_neg(8);
    n_vec++;
    if (log_q.size() !== 2) begin
      n_miss++; $display("FAIL rstmid_len got %0d want 2", log_q.size());
    end
    if (log_q.size() >= 2) begin
      n_vec++;
      if (log_q[0].snap !== pk(FW, 16'h0180, 8'h11)) begin
        n_miss++; $display("FAIL rstmid_pch got %h want %h", log_q[0].snap, pk(FW, 16'h0180, 8'h11));
      end
      n_vec++;
      if (log_q[1].snap !== pk(FW, 16'h017F, 8'h11)) begin
        n_miss++; $display("FAIL rstmid_pcl got %h want %h", log_q[1].snap, pk(FW, 16'h017F, 8'h11));
      end
    end
  endtask

  task automatic test_hijack();
    logic [29:0] e[6];
    logic [15:0] want_pcn;
    @(negedge clk);
    log_q.delete();
    status = 8'h00; pc = 16'hC123; sp = 8'hFD; irq_l = 1'b0; instr_boundary = 1'b1;
    @(negedge clk);
    instr_boundary = 1'b0; irq_l = 1'b1;
    @(negedge clk);
    nmi_l = 1'b0;
    wait_neg(7);
    e[0] = pk(FW, 16'h01FD, 8'hC1); e[1] = pk(FW, 16'h01FC, 8'h23);
    e[2] = pk(FW, 16'h01FB, 8'h20); e[5] = pk(FL, 16'h0000, 8'h00);
`ifdef IRQ_SEQ_NMI_HIJACK_EN
    e[3] = pk(FR, 16'hFFFA, 8'h00); e[4] = pk(FR, 16'hFFFB, 8'h00); want_pcn = 16'h5678;
`else
    e[3] = pk(FR, 16'hFFFE, 8'h00); e[4] = pk(FR, 16'hFFFF, 8'h00); want_pcn = 16'h1234;
`endif
    n_vec++;
    if (log_q.size() !== 6) begin
      n_miss++; $display("FAIL hij_len got %0d want 6", log_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        n_vec++;
        if (log_q[i].snap !== e[i]) begin
          n_miss++; $display("FAIL hij_cyc%0d got %h want %h", i, log_q[i].snap, e[i]);
        end
      end
    end
    if (log_q.size() >= 6) begin
      n_vec++;
      if (log_q[5].pcn !== want_pcn) begin
        n_miss++; $display("FAIL hij_pc_new got %h want %h", log_q[5].pcn, want_pcn);
      end
    end
    // Next boundary with no request: only a still-pending NMI can start.
    log_q.delete();
    pc = 16'h4000; sp = 8'hF0; status = 8'h00; instr_boundary = 1'b1;
    @(negedge clk);
    instr_boundary = 1'b0;
    wait_neg(8);
`ifdef IRQ_SEQ_NMI_HIJACK_EN
    n_vec++;
    if (log_q.size() !== 0) begin
      n_miss++; $display("FAIL hij_pending got %0d entries want 0", log_q.size());
    end
`else
    e[0] = pk(FW, 16'h01F0, 8'h40); e[1] = pk(FW, 16'h01EF, 8'h00);
    e[2] = pk(FW, 16'h01EE, 8'h20); e[3] = pk(FR, 16'hFFFA, 8'h00);
    e[4] = pk(FR, 16'hFFFB, 8'h00); e[5] = pk(FL, 16'h0000, 8'h00);
    n_vec++;
    if (log_q.size() !== 6) begin
      n_miss++; $display("FAIL late_nmi_len got %0d want 6", log_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        n_vec++;
        if (log_q[i].snap !== e[i]) begin
          n_miss++; $display("FAIL late_nmi_cyc%0d got %h want %h", i, log_q[i].snap, e[i]);
        end
      end
    end
`endif
    nmi_l = 1'b1;
    wait_neg(2);
  endtask

  initial begin
    reset_l        = 1'b0;
    instr_boundary = 1'b0;
    brk_req        = 1'b0;
    irq_l          = 1'b1;
    nmi_l          = 1'b1;
    status         = 8'h00;
    pc             = 16'h0000;
    sp             = 8'h00;
    test_reset();
    test_irq();
    test_masked_irq();
    test_brk_nmi();
    test_sp_wrap();
    test_back_to_back();
    test_reset_mid();
    test_hijack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
